// File: rtl/ledframe_tx_pkg.sv
// Shared encodings and frame constants for the APA102-class strip serialiser.
// The upstream wave generator uses the same frame-type encodings.
package ledframe_tx_pkg;

    typedef enum logic [1:0] {
        INPUT_TYPE_START = 2'd0,
        INPUT_TYPE_LED   = 2'd1,
        INPUT_TYPE_END   = 2'd2,
        INPUT_TYPE_RSVD  = 2'd3
    } frame_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } tx_state_t;

    localparam int          FRAME_W        = 32;
    localparam logic [2:0]  LED_HEADER     = 3'b111;
    localparam int          STRING_SIZE    = 24;
    localparam int          NUMBER_STRINGS = 47;

    // Frame word for a request; reserved type yields zero but is never accepted.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [1:0] kind,
        input logic [4:0] bright,
        input logic [7:0] blue,
        input logic [7:0] green,
        input logic [7:0] red
    );
        logic [FRAME_W-1:0] word;
        case (kind)
            INPUT_TYPE_LED: word = {LED_HEADER, bright, blue, green, red};
            INPUT_TYPE_END: word = {FRAME_W{1'b1}};
            default:        word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ledframe_tx_if.sv
// Request/handshake and serial-line bundle between the strip sequencer and the serialiser.
interface ledframe_tx_if;

    logic [7:0] blue_input;
    logic [7:0] green_input;
    logic [7:0] red_input;
    logic [1:0] type_input;
    logic       ledframe_start;
    logic       ledframe_busy;
    logic       mosi;
    logic       sck;

    modport master (
        output blue_input, green_input, red_input, type_input, ledframe_start,
        input  ledframe_busy, mosi, sck
    );

    modport slave (
        input  blue_input, green_input, red_input, type_input, ledframe_start,
        output ledframe_busy, mosi, sck
    );

endinterface

// File: rtl/ledframe_tx.sv
// Shifts one 32-bit strip frame MSB-first onto mosi with a divided sck.
// Divider, bit counter and shift register live in one state machine.
module ledframe_tx
    import ledframe_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned BRIGHTNESS = 31
) (
    input  logic           ledframe_clk,
    input  logic           ledframe_reset,
    ledframe_tx_if.slave   bus
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BRIGHT5  = 5'(BRIGHTNESS);

    tx_state_t          r_state;
    logic [7:0]         r_div_cnt;
    logic [4:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic               r_busy;
    logic               r_sck;

    logic               w_accept;
    logic               w_div_done;
    logic [FRAME_W-1:0] w_word;

    assign w_accept   = bus.ledframe_start && (bus.type_input != INPUT_TYPE_RSVD);
    assign w_div_done = (r_div_cnt == DIV_LAST);
    assign w_word     = build_frame(bus.type_input, BRIGHT5,
                                    bus.blue_input, bus.green_input, bus.red_input);

    // mosi is the shift register MSB; the final shift empties it so idle mosi is 0.
    assign bus.mosi          = r_shift[FRAME_W-1];
    assign bus.sck           = r_sck;
    assign bus.ledframe_busy = r_busy;

    always_ff @(posedge ledframe_clk or posedge ledframe_reset) begin
        if (ledframe_reset) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_sck     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= w_word;
                        r_sck     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= 5'd31;
                        r_div_cnt <= '0;
                        r_state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_div_done) begin
                        r_sck     <= 1'b1;
                        r_div_cnt <= '0;
                        r_state   <= ST_HIGH;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (w_div_done) begin
                        r_sck     <= 1'b0;
                        r_div_cnt <= '0;
                        r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                        if (r_bit_cnt == 5'd0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                            r_state   <= ST_LOW;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ledframe_tx.sv
// Bench for ledframe_tx: one instance at CLK_DIV=4, one at CLK_DIV=1, checked against a frame-level model.
module tb_ledframe_tx;

    localparam int BRIGHT = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ledframe_tx_if bus_a ();
    ledframe_tx_if bus_b ();

    ledframe_tx #(.CLK_DIV(4), .BRIGHTNESS(BRIGHT)) dut_a (
        .ledframe_clk   (clk),
        .ledframe_reset (rst),
        .bus            (bus_a)
    );

    ledframe_tx #(.CLK_DIV(1), .BRIGHTNESS(BRIGHT)) dut_b (
        .ledframe_clk   (clk),
        .ledframe_reset (rst),
        .bus            (bus_b)
    );

    logic [7:0] blue  [2];
    logic [7:0] green [2];
    logic [7:0] red   [2];
    logic [1:0] typ   [2];
    logic       start [2];
    logic [1:0] busy, mosi, sck;

    assign bus_a.blue_input     = blue[0];
    assign bus_a.green_input    = green[0];
    assign bus_a.red_input      = red[0];
    assign bus_a.type_input     = typ[0];
    assign bus_a.ledframe_start = start[0];
    assign bus_b.blue_input     = blue[1];
    assign bus_b.green_input    = green[1];
    assign bus_b.red_input      = red[1];
    assign bus_b.type_input     = typ[1];
    assign bus_b.ledframe_start = start[1];
    assign busy = {bus_b.ledframe_busy, bus_a.ledframe_busy};
    assign mosi = {bus_b.mosi, bus_a.mosi};
    assign sck  = {bus_b.sck, bus_a.sck};

    int checks   = 0;
    int failures = 0;

    // Observations decoded from the serial lines, per instance.
    int          rises [2];
    int          viol  [2];
    logic [31:0] got_q   [2][$];
    int          len_q   [2][$];
    int          first_q [2][$];
    int          gap_q   [2][$];
    logic [31:0] exp_q   [2][$];

    // Line monitor: decodes words on sck rises, measures busy windows and gaps.
    initial begin
        logic        ps [2];
        logic        pm [2];
        logic        pb [2];
        logic [31:0] acc [2];
        int          nb [2];
        int          bc [2];
        int          lc [2];
        bit          sf [2];
        for (int i = 0; i < 2; i++) begin
            ps[i] = 0; pm[i] = 0; pb[i] = 0; acc[i] = 0;
            nb[i] = 0; bc[i] = 0; lc[i] = 0; sf[i] = 0;
            rises[i] = 0; viol[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic b, m, s;
                b = busy[i]; m = mosi[i]; s = sck[i];
                if (rst) begin
                    nb[i] = 0; bc[i] = 0; lc[i] = 0; sf[i] = 0;
                end else begin
                    if (m !== pm[i] && !(ps[i] && !s) && !(b && !pb[i])) viol[i]++;
                    if (b && !pb[i]) begin
                        if (sf[i]) gap_q[i].push_back(lc[i]);
                        bc[i] = 0;
                    end
                    if (s && !ps[i]) begin
                        rises[i]++;
                        if (nb[i] == 0) first_q[i].push_back(bc[i]);
                        acc[i] = {acc[i][30:0], m};
                        nb[i]++;
                        if (nb[i] == 32) begin
                            got_q[i].push_back(acc[i]);
                            nb[i] = 0;
                        end
                    end
                    if (b) bc[i]++;
                    if (pb[i] && !b) begin
                        len_q[i].push_back(bc[i]);
                        sf[i] = 1;
                        lc[i] = 0;
                    end
                    if (!b) lc[i]++;
                end
                ps[i] = s; pm[i] = m; pb[i] = b;
            end
        end
    end

    function automatic logic [31:0] model(int t, int b, int g, int r);
        longint v;
        if (t == 0) return 32'h0;
        if (t == 2) return 32'hFFFF_FFFF;
        v = 7 * longint'(536870912) + longint'(BRIGHT % 32) * 16777216 + b * 65536 + g * 256 + r;
        return v[31:0];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(int i, int t, int b, int g, int r);
        typ[i] = 2'(t); blue[i] = 8'(b); green[i] = 8'(g); red[i] = 8'(r);
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        typ[i] = 2'($urandom); blue[i] = 8'($urandom); green[i] = 8'($urandom); red[i] = 8'($urandom);
    endtask

    task automatic send(int i, int t, int b, int g, int r);
        logic [31:0] w;
        w = model(t, b, g, r);
        pulse(i, t, b, g, r);
        exp_q[i].push_back(w);
        check($sformatf("accept_busy[%0d]", i), 32'(busy[i]), 32'd1);
        check($sformatf("accept_mosi[%0d]", i), 32'(mosi[i]), 32'(w[31]));
    endtask

    task automatic wait_idle(int i, int budget);
        for (int k = 0; k < budget && busy[i]; k++) step();
        check($sformatf("idle_timeout[%0d]", i), 32'(busy[i]), 32'd0);
    endtask

    task automatic drain(int i, int d);
        check($sformatf("frame_count[%0d]", i), got_q[i].size(), exp_q[i].size());
        while (exp_q[i].size() > 0 && got_q[i].size() > 0)
            check($sformatf("frame_word[%0d]", i), got_q[i].pop_front(), exp_q[i].pop_front());
        while (len_q[i].size() > 0)
            check($sformatf("busy_len[%0d]", i), len_q[i].pop_front(), 64 * d);
        while (first_q[i].size() > 0)
            check($sformatf("first_rise[%0d]", i), first_q[i].pop_front(), d);
        exp_q[i].delete();
        got_q[i].delete();
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 2; i++) begin
            blue[i] = 0; green[i] = 0; red[i] = 0; typ[i] = 0; start[i] = 0;
        end

        rst = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_busy[%0d]", i), 32'(busy[i]), 32'd0);
            check($sformatf("reset_mosi[%0d]", i), 32'(mosi[i]), 32'd0);
            check($sformatf("reset_sck[%0d]", i), 32'(sck[i]), 32'd0);
        end
        rst = 1'b0;
        step();

        // Directed LED frame
        r0 = rises[0];
        send(0, 1, 8'hA5, 8'h3C, 8'h0F);
        wait_idle(0, 1000);
        step();
        check("led_rises", rises[0] - r0, 32);
        check("led_idle_mosi", 32'(mosi[0]), 32'd0);
        drain(0, 4);

        // START then END
        send(0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        wait_idle(0, 1000);
        step();
        send(0, 2, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        wait_idle(0, 1000);
        check("end_mosi", 32'(mosi[0]), 32'd0);
        check("end_sck", 32'(sck[0]), 32'd0);
        drain(0, 4);

        // Start while busy is ignored
        send(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        repeat (99) step();
        pulse(0, 1, 8'h11, 8'h11, 8'h11);
        wait_idle(0, 1000);
        repeat (5) step();
        check("busy_ignore_idle", 32'(busy[0]), 32'd0);
        drain(0, 4);

        // Reserved type is ignored
        r0 = rises[0];
        pulse(0, 3, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        check("rsvd_busy", 32'(busy[0]), 32'd0);
        repeat (20) step();
        check("rsvd_rises", rises[0] - r0, 0);
        check("rsvd_busy_late", 32'(busy[0]), 32'd0);

        // Random frames, back-to-back at CLK_DIV=4
        for (int k = 0; k < 6; k++) begin
            send(0, $urandom_range(0, 2), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            wait_idle(0, 1000);
        end
        drain(0, 4);

        // Reset mid-frame abandons the frame
        send(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        repeat (50) step();
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_mosi", 32'(mosi[0]), 32'd0);
        check("midrst_sck", 32'(sck[0]), 32'd0);
        exp_q[0].delete();
        repeat (3) step();
        rst = 1'b0;
        r0 = rises[0];
        repeat (300) step();
        check("midrst_no_resume", rises[0] - r0, 0);
        check("midrst_busy_late", 32'(busy[0]), 32'd0);
        drain(0, 4);

        // Full refresh, CLK_DIV=1, each frame issued the first cycle busy is low
        wait_idle(1, 10);
        send(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        for (int k = 0; k < 47; k++) begin
            wait_idle(1, 200);
            send(1, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        wait_idle(1, 200);
        send(1, 2, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        wait_idle(1, 200);
        repeat (4) step();
        check("b2b_gap_count", gap_q[1].size(), 48);
        while (gap_q[1].size() > 0)
            check("b2b_gap", gap_q[1].pop_front(), 1);
        drain(1, 1);

        check("mosi_stable[0]", viol[0], 0);
        check("mosi_stable[1]", viol[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
